// File: rtl/dma_mc_fsm.sv
// rtl/dma_mc_fsm.sv - multi-channel DMA control FSM with round-robin bus arbitration
// Each channel runs IDLE/PEND/RUN/DONE; exactly one RUN owner drives the shared streamers.
module dma_mc_fsm #(
  parameter int NUM_CH       = 4,
  parameter int ADDR_W       = 32,
  parameter bit ABORT_ON_ERR = 1'b1,
  parameter int CH_W         = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_CH-1:0]        dma_go_i,
  input  logic [NUM_CH-1:0]        dma_abort_i,
  output logic [NUM_CH-1:0]        dma_done_o,
  output logic [NUM_CH-1:0]        dma_active_o,
  output logic [NUM_CH-1:0]        dma_pend_o,
  output logic [NUM_CH-1:0]        clear_dma_o,
  output logic [NUM_CH-1:0]        dma_err_valid_o,
  output logic [2*NUM_CH-1:0]      dma_err_src_o,
  output logic [ADDR_W*NUM_CH-1:0] dma_err_addr_o,
  output logic                     grant_valid_o,
  output logic [CH_W-1:0]          grant_ch_o,
  input  logic                     axi_pend_txn_i,
  input  logic                     axi_err_valid_i,
  input  logic [ADDR_W-1:0]        axi_err_addr_i,
  output logic                     stream_rd_valid_o,
  input  logic                     stream_rd_done_i,
  input  logic                     stream_rd_err_valid_i,
  input  logic [ADDR_W-1:0]        stream_rd_err_addr_i,
  output logic                     stream_wr_valid_o,
  input  logic                     stream_wr_done_i,
  input  logic                     stream_wr_err_valid_i,
  input  logic [ADDR_W-1:0]        stream_wr_err_addr_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_RUN, ST_DONE} ch_state_e;

  localparam logic [1:0] SRC_AXI = 2'd1;
  localparam logic [1:0] SRC_RD  = 2'd2;
  localparam logic [1:0] SRC_WR  = 2'd3;

  ch_state_e         st_ff [NUM_CH];
  ch_state_e         st_nxt [NUM_CH];
  logic [NUM_CH-1:0] rd_done_ff, rd_done_nxt;
  logic [NUM_CH-1:0] wr_done_ff, wr_done_nxt;
  logic [NUM_CH-1:0] clr_ff, clr_nxt;
  logic [NUM_CH-1:0] err_v_ff, err_v_nxt;
  logic [1:0]        err_src_ff [NUM_CH];
  logic [1:0]        err_src_nxt [NUM_CH];
  logic [ADDR_W-1:0] err_addr_ff [NUM_CH];
  logic [ADDR_W-1:0] err_addr_nxt [NUM_CH];
  logic [CH_W-1:0]   last_ff, last_nxt;

  logic              own_valid;
  logic [CH_W-1:0]   own_ch;
  logic              own_stop;
  logic              pick_valid;
  logic [CH_W-1:0]   pick_ch;
  logic [CH_W:0]     cand;
  logic              any_err;
  logic [1:0]        err_src_in;
  logic [ADDR_W-1:0] err_addr_in;

  always_comb begin
    own_valid = 1'b0;
    own_ch    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (st_ff[i] == ST_RUN) begin
        own_valid = 1'b1;
        own_ch    = CH_W'(i);
      end
    end
  end

  // The owner stops streaming on abort or, when enabled, once an error is on record.
  assign own_stop = own_valid & (dma_abort_i[own_ch] | (ABORT_ON_ERR & err_v_ff[own_ch]));

  // Round-robin: first non-aborting PEND channel after last_ff, only while nobody is in RUN.
  always_comb begin
    pick_valid = 1'b0;
    pick_ch    = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = {1'b0, last_ff} + (CH_W+1)'(k);
      if (cand >= (CH_W+1)'(NUM_CH)) cand = cand - (CH_W+1)'(NUM_CH);
      if (!pick_valid && st_ff[cand[CH_W-1:0]] == ST_PEND && !dma_abort_i[cand[CH_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_ch    = cand[CH_W-1:0];
      end
    end
    if (own_valid) pick_valid = 1'b0;
  end

  always_comb begin
    any_err     = axi_err_valid_i | stream_rd_err_valid_i | stream_wr_err_valid_i;
    err_src_in  = 2'd0;
    err_addr_in = '0;
    if (axi_err_valid_i) begin
      err_src_in  = SRC_AXI;
      err_addr_in = axi_err_addr_i;
    end else if (stream_rd_err_valid_i) begin
      err_src_in  = SRC_RD;
      err_addr_in = stream_rd_err_addr_i;
    end else if (stream_wr_err_valid_i) begin
      err_src_in  = SRC_WR;
      err_addr_in = stream_wr_err_addr_i;
    end
  end

  always_comb begin
    last_nxt = last_ff;
    for (int i = 0; i < NUM_CH; i++) begin
      st_nxt[i]       = st_ff[i];
      rd_done_nxt[i]  = rd_done_ff[i];
      wr_done_nxt[i]  = wr_done_ff[i];
      clr_nxt[i]      = 1'b0;
      err_v_nxt[i]    = err_v_ff[i];
      err_src_nxt[i]  = err_src_ff[i];
      err_addr_nxt[i] = err_addr_ff[i];
      case (st_ff[i])
        ST_IDLE: begin
          if (dma_go_i[i] && !dma_abort_i[i]) begin
            st_nxt[i]       = ST_PEND;
            err_v_nxt[i]    = 1'b0;
            err_src_nxt[i]  = 2'd0;
            err_addr_nxt[i] = '0;
          end
        end
        ST_PEND: begin
          if (dma_abort_i[i]) begin
            st_nxt[i] = ST_IDLE;
          end else if (pick_valid && pick_ch == CH_W'(i)) begin
            st_nxt[i] = ST_RUN;
            last_nxt  = pick_ch;
          end
        end
        ST_RUN: begin
          if (stream_rd_done_i) rd_done_nxt[i] = 1'b1;
          if (stream_wr_done_i) wr_done_nxt[i] = 1'b1;
          if (!err_v_ff[i] && any_err) begin
            err_v_nxt[i]    = 1'b1;
            err_src_nxt[i]  = err_src_in;
            err_addr_nxt[i] = err_addr_in;
          end
          if (!axi_pend_txn_i && (own_stop || (rd_done_ff[i] && wr_done_ff[i])))
            st_nxt[i] = ST_DONE;
        end
        ST_DONE: begin
          rd_done_nxt[i] = 1'b0;
          wr_done_nxt[i] = 1'b0;
          if (!dma_go_i[i]) begin
            st_nxt[i]  = ST_IDLE;
            clr_nxt[i] = 1'b1;
          end
        end
        default: st_nxt[i] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_ff    <= CH_W'(NUM_CH - 1);
      rd_done_ff <= '0;
      wr_done_ff <= '0;
      clr_ff     <= '0;
      err_v_ff   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        st_ff[i]       <= ST_IDLE;
        err_src_ff[i]  <= 2'd0;
        err_addr_ff[i] <= '0;
      end
    end else begin
      last_ff    <= last_nxt;
      rd_done_ff <= rd_done_nxt;
      wr_done_ff <= wr_done_nxt;
      clr_ff     <= clr_nxt;
      err_v_ff   <= err_v_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        st_ff[i]       <= st_nxt[i];
        err_src_ff[i]  <= err_src_nxt[i];
        err_addr_ff[i] <= err_addr_nxt[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      dma_done_o[i]                     = (st_ff[i] == ST_DONE);
      dma_active_o[i]                   = (st_ff[i] == ST_RUN);
      dma_pend_o[i]                     = (st_ff[i] == ST_PEND);
      dma_err_src_o[2*i +: 2]           = err_src_ff[i];
      dma_err_addr_o[ADDR_W*i +: ADDR_W] = err_addr_ff[i];
    end
  end

  assign clear_dma_o       = clr_ff;
  assign dma_err_valid_o   = err_v_ff;
  assign grant_valid_o     = own_valid;
  assign grant_ch_o        = own_ch;
  assign stream_rd_valid_o = own_valid & ~own_stop & ~rd_done_ff[own_ch];
  assign stream_wr_valid_o = own_valid & ~own_stop & ~wr_done_ff[own_ch];

endmodule
